multi_adder_acc: RTL and testbench

- Parametrised N-operand adder with optional accumulate mode, valid/ready handshaking and a configurable pipeline depth.
- Sums N unsigned W-bit operands plus a carry-in per beat. Either emits each sum directly or accumulates a burst of beats into a saturating accumulator.
- Sits in the datapath as the registered summation stage ahead of downstream consumers that may apply backpressure.

---
 rtl/multi_adder_acc.sv | 108 ++++++++++
 tb/tb_multi_adder_acc.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_adder_acc.sv
// N-operand W-bit adder with carry-in, optional saturating burst accumulation,
// valid/ready handshake and a 1- or 2-stage pipeline.
module multi_adder_acc #(
  parameter int W    = 8,
  parameter int N    = 4,
  parameter int PIPE = 2,
  parameter int AW   = 16,
  localparam int SW  = W + $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W:0]   ins,
  input  logic           in_acc,
  input  logic           in_last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AW-1:0]  out_sum,
  output logic           out_zero,
  output logic           out_ovf
);

  logic          stall, take;
  logic [SW-1:0] beat;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign take     = in_valid && in_ready;

  always_comb begin
    beat = SW'(ins[N*W]);
    for (int k = 0; k < N; k++) beat = beat + SW'(ins[k*W +: W]);
  end

  // Source feeding the accumulate/output stage: either registered tree or raw beat.
  logic          src_vld, src_acc, src_last;
  logic [SW-1:0] src_sum;

  generate
    if (PIPE == 2) begin : g_pipe2
      logic          s_vld, s_acc, s_last;
      logic [SW-1:0] s_sum;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_vld  <= 1'b0;
          s_acc  <= 1'b0;
          s_last <= 1'b0;
          s_sum  <= '0;
        end else if (!stall) begin
          s_vld <= take;
          if (take) begin
            s_acc  <= in_acc;
            s_last <= in_last;
            s_sum  <= beat;
          end
        end
      end
      assign src_vld  = s_vld;
      assign src_acc  = s_acc;
      assign src_last = s_last;
      assign src_sum  = s_sum;
    end else begin : g_pipe1
      assign src_vld  = take;
      assign src_acc  = in_acc;
      assign src_last = in_last;
      assign src_sum  = beat;
    end
  endgenerate

  logic [AW-1:0] acc, acc_res;
  logic          ovf_flag, sat;
  logic [AW:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + (AW+1)'(src_sum);
  assign sat     = acc_sum[AW];
  assign acc_res = sat ? '1 : acc_sum[AW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_zero  <= 1'b0;
      out_ovf   <= 1'b0;
      acc       <= '0;
      ovf_flag  <= 1'b0;
    end else if (!stall) begin
      out_valid <= src_vld && (!src_acc || src_last);
      if (src_vld) begin
        if (!src_acc) begin
          out_sum  <= AW'(src_sum);
          out_zero <= (src_sum == '0);
          out_ovf  <= 1'b0;
        end else if (src_last) begin
          out_sum  <= acc_res;
          out_zero <= (acc_res == '0);
          out_ovf  <= ovf_flag | sat;
          acc      <= '0;
          ovf_flag <= 1'b0;
        end else begin
          acc      <= acc_res;
          ovf_flag <= ovf_flag | sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_adder_acc.sv
// Scoreboard bench for multi_adder_acc: a PIPE=2/AW=16 instance and a
// PIPE=1/AW=10 instance, driven one at a time through a shared stimulus bus.
module tb_multi_adder_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [32:0] ins = '0;
  logic        in_acc = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  int          sel = 0;
  logic        rmode = 1'b0;
  int          cyc = 0;

  logic        iv0, iv1, rdy0, rdy1, ov0, ov1, z0, z1, o0, o1;
  logic [15:0] sum0;
  logic [9:0]  sum1;

  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);

  multi_adder_acc #(.W(8), .N(4), .PIPE(2), .AW(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .ins(ins),
    .in_acc(in_acc), .in_last(in_last), .out_valid(ov0), .out_ready(out_ready),
    .out_sum(sum0), .out_zero(z0), .out_ovf(o0));

  multi_adder_acc #(.W(8), .N(4), .PIPE(1), .AW(10)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .ins(ins),
    .in_acc(in_acc), .in_last(in_last), .out_valid(ov1), .out_ready(out_ready),
    .out_sum(sum1), .out_zero(z1), .out_ovf(o1));

  typedef struct {logic [15:0] sum; logic zero; logic ovf;} exp_t;
  exp_t q[$];
  int   tests = 0, fails = 0;
  int   m_acc = 0;
  logic m_ovf = 1'b0;

  // Downstream ready: always 1, or the repeating 1,0,0,1 pattern.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    out_ready = rmode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
  end

  // Output monitor: ready rule, output hold while stalled, scoreboard pop.
  bit          prev_stall [2];
  logic [17:0] prev [2];
  logic        mv, mr, mz, mo;
  logic [15:0] ms;
  exp_t        me;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        prev_stall[i] = 1'b0;
      end else begin
        mv = i ? ov1 : ov0;
        mr = i ? rdy1 : rdy0;
        mz = i ? z1 : z0;
        mo = i ? o1 : o0;
        ms = i ? {6'd0, sum1} : sum0;
        tests++;
        if (mr !== !(mv && !out_ready)) begin
          fails++;
          $display("FAIL in_ready dut%0d: got %b want %b", i, mr, !(mv && !out_ready));
        end
        if (prev_stall[i] && mv) begin
          tests++;
          if ({ms, mz, mo} !== prev[i]) begin
            fails++;
            $display("FAIL hold dut%0d: got %h want %h", i, {ms, mz, mo}, prev[i]);
          end
        end
        if (mv && out_ready) begin
          tests++;
          if (i != sel || q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_out dut%0d: got sum %0d, nothing expected", i, ms);
          end else begin
            me = q.pop_front();
            if ({ms, mz, mo} !== {me.sum, me.zero, me.ovf}) begin
              fails++;
              $display("FAIL result dut%0d: got sum=%0d z=%b o=%b want sum=%0d z=%b o=%b",
                       i, ms, mz, mo, me.sum, me.zero, me.ovf);
            end
          end
        end
        prev_stall[i] = mv && !out_ready;
        prev[i]       = {ms, mz, mo};
      end
    end
  end

  task automatic send(input logic [7:0] a, b, c, d, input logic cin, ac, la);
    int s, tot, amax, n;
    bit st;
    exp_t e;
    ins = {cin, d, c, b, a};
    in_acc = ac; in_last = la; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if ((sel == 0 ? rdy0 : rdy1) === 1'b1) break;
      n++;
      if (n > 200) begin
        fails++;
        $display("FAIL accept_timeout: got in_ready=0 for 200 cycles, want 1");
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    s = a + b + c + d + cin;
    if (!ac) begin
      e.sum = 16'(s); e.zero = (s == 0); e.ovf = 1'b0; q.push_back(e);
    end else begin
      amax = (sel == 0) ? 65535 : 1023;
      tot  = m_acc + s;
      st   = tot > amax;
      if (st) tot = amax;
      if (la) begin
        e.sum = 16'(tot); e.zero = (tot == 0); e.ovf = m_ovf | st; q.push_back(e);
        m_acc = 0; m_ovf = 1'b0;
      end else begin
        m_acc = tot; m_ovf = m_ovf | st;
      end
    end
    #1;
    in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d results outstanding, want 0", q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if ({ov0, ov1, sum0, sum1, z0, z1, o0, o1} !== '0 || {rdy0, rdy1} !== 2'b11) begin
      fails++;
      $display("FAIL reset: got v=%b%b sum=%0d/%0d z=%b%b o=%b%b rdy=%b%b want zeros, rdy=11",
               ov0, ov1, sum0, sum1, z0, z1, o0, o1, rdy0, rdy1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single(input int s);
    int p;
    sel = s;
    p = (s == 0) ? 2 : 1;
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < p; k++) begin
      tests++;
      if ((s == 0 ? ov0 : ov1) !== 1'b0) begin
        fails++;
        $display("FAIL latency_early dut%0d: got out_valid=1 at +%0d, want 0", s, k);
      end
      @(posedge clk); #1;
    end
    tests++;
    if ((s == 0 ? ov0 : ov1) !== 1'b1) begin
      fails++;
      $display("FAIL latency dut%0d: got out_valid=0 at +%0d, want 1", s, p);
    end
    send(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back(input int s);
    sel = s;
    rmode = 1'b1;
    for (int k = 0; k < 10; k++) send(8'(k), 8'(k), 8'(k), 8'(k), 1'b0, 1'b0, 1'b0);
    drain();
    rmode = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic test_accumulate;
    sel = 0;
    for (int k = 0; k < 3; k++) send(8'h10, 8'h10, 8'h10, 8'h10, 1'b0, 1'b1, k == 2);
    send(8'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    send(8'd5, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    send(8'd3, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    send(8'd2, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
    send(8'd9, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    send(8'd4, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    send(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_saturation;
    sel = 1;
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b1);
    send(8'd5, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    send(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0);
    send(8'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    drain();
  endtask

  task automatic test_reset_midburst;
    sel = 0;
    send(8'd25, 8'd25, 8'd25, 8'd25, 1'b0, 1'b1, 1'b0);
    send(8'd25, 8'd25, 8'd25, 8'd25, 1'b0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    m_acc = 0; m_ovf = 1'b0;
    @(negedge clk);
    tests++;
    if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: got out_valid=%b in_ready=%b want 0/1", ov0, rdy0);
    end
    @(posedge clk); #1;
    tests++;
    if (ov0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_edge: got out_valid=%b want 0", ov0);
    end
    rst = 1'b0;
    send(8'd7, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1);
    drain();
  endtask

  initial begin
    test_reset();
    test_single(0);
    test_single(1);
    test_back_to_back(0);
    test_back_to_back(1);
    test_accumulate();
    test_saturation();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
